minmax_tracker: RTL and testbench



---
 rtl/minmax_tracker.sv | 119 +++++++++++
 tb/tb_minmax_tracker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/minmax_tracker.sv
// minmax_tracker: streaming unsigned min/max/count tracker for one packet
// of S-bit samples delivered over a valid/ready handshake.
// Optional feature: define MINMAX_IDX_EN to add min_idx/max_idx, the 0-based
// index of the first occurrence of each extremum.
module minmax_tracker #(
   parameter int S  = 8,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   input  logic [S-1:0]  in_data,
   input  logic          in_last,
   output logic          in_ready,
   output logic [S-1:0]  min_out,
   output logic [S-1:0]  max_out,
   output logic [CW-1:0] count,
   output logic          done
`ifdef MINMAX_IDX_EN
   ,
   output logic [CW-1:0] min_idx,
   output logic [CW-1:0] max_idx
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic          accept;
   logic          first;
   logic          lt_min;
   logic          gt_max;
   logic [CW-1:0] count_inc;

   // Handshake flags decode straight from the state register.
   assign in_ready = (state == RUN);
   assign done     = (state == DONE);

   // start wins over a same-cycle sample, so the sample is dropped.
   assign accept    = in_valid && in_ready && !start;
   assign first     = (count == '0);
   assign lt_min    = (in_data < min_out);
   assign gt_max    = (max_out < in_data);
   assign count_inc = (count == '1) ? count : count + 1'b1;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: start from any state opens a packet; last accept closes it.
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = RUN;
      end else begin
         case (state)
            RUN:     if (in_valid && in_last) state_nxt = DONE;
            default: state_nxt = state;
         endcase
      end
   end

   // Statistics registers: cleared by start, updated on every accepted sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_out <= '0;
         max_out <= '0;
         count   <= '0;
`ifdef MINMAX_IDX_EN
         min_idx <= '0;
         max_idx <= '0;
`endif
      end else if (start) begin
         min_out <= '0;
         max_out <= '0;
         count   <= '0;
`ifdef MINMAX_IDX_EN
         min_idx <= '0;
         max_idx <= '0;
`endif
      end else if (accept) begin
         count <= count_inc;
         if (first) begin
            min_out <= in_data;
            max_out <= in_data;
`ifdef MINMAX_IDX_EN
            min_idx <= '0;
            max_idx <= '0;
`endif
         end else begin
            // Strict compares: ties keep the earlier index.
            if (lt_min) begin
               min_out <= in_data;
`ifdef MINMAX_IDX_EN
               min_idx <= count;
`endif
            end
            if (gt_max) begin
               max_out <= in_data;
`ifdef MINMAX_IDX_EN
               max_idx <= count;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker: a default instance (CW=8) and a CW=3
// instance share all inputs so counter saturation can be observed against
// the unsaturated count. Index checks apply when MINMAX_IDX_EN is defined.
module tb_minmax_tracker;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;

   logic       in_ready, done, s_in_ready, s_done;
   logic [7:0] min_out, max_out, count;
   logic [7:0] s_min_out, s_max_out;
   logic [2:0] s_count;
`ifdef MINMAX_IDX_EN
   logic [7:0] min_idx, max_idx;
   logic [2:0] s_min_idx, s_max_idx;
`endif

   int unsigned n_checks;
   int unsigned n_fail;

   minmax_tracker #(.S(8), .CW(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_last  (in_last),
      .in_ready (in_ready),
      .min_out  (min_out),
      .max_out  (max_out),
      .count    (count),
      .done     (done)
`ifdef MINMAX_IDX_EN
      ,
      .min_idx  (min_idx),
      .max_idx  (max_idx)
`endif
   );

   minmax_tracker #(.S(8), .CW(3)) dut_sat (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_last  (in_last),
      .in_ready (s_in_ready),
      .min_out  (s_min_out),
      .max_out  (s_max_out),
      .count    (s_count),
      .done     (s_done)
`ifdef MINMAX_IDX_EN
      ,
      .min_idx  (s_min_idx),
      .max_idx  (s_max_idx)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h55;
      in_last  = 1'b0;

      // Reset then idle with in_valid held high and no start.
      #12;
      check("rst_ready", in_ready, 0);
      check("rst_done",  done, 0);
      check("rst_min",   min_out, 0);
      check("rst_max",   max_out, 0);
      check("rst_count", count, 0);
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      check("idle_ready", in_ready, 0);
      check("idle_count", count, 0);
      check("idle_min",   min_out, 0);
      check("idle_done",  done, 0);
      in_valid = 1'b0;

      // Basic packet.
      pulse_start();
      check("run_ready", in_ready, 1);
      check("run_count", count, 0);
      send(8'h40, 1'b0);
      send(8'h10, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h10, 1'b0);
      check("pre_last_done", done, 0);
      check("pre_last_cnt",  count, 4);
      send(8'h80, 1'b1);
      check("pkt_done",  done, 1);
      check("pkt_ready", in_ready, 0);
      check("pkt_min",   min_out, 8'h10);
      check("pkt_max",   max_out, 8'hF0);
      check("pkt_count", count, 5);
`ifdef MINMAX_IDX_EN
      check("pkt_min_idx", min_idx, 1);
      check("pkt_max_idx", max_idx, 2);
`endif

      // Backpressure in DONE: samples ignored, results stable.
      in_valid = 1'b1;
      in_data  = 8'h00;
      tick();
      tick();
      tick();
      in_valid = 1'b0;
      check("bp_done",  done, 1);
      check("bp_min",   min_out, 8'h10);
      check("bp_max",   max_out, 8'hF0);
      check("bp_count", count, 5);

      // Restart from DONE.
      pulse_start();
      check("rs_done",  done, 0);
      check("rs_ready", in_ready, 1);
      check("rs_count", count, 0);
      check("rs_min",   min_out, 0);
      check("rs_max",   max_out, 0);
      send(8'hFF, 1'b0);
      send(8'h00, 1'b1);
      check("rs_pkt_min",   min_out, 8'h00);
      check("rs_pkt_max",   max_out, 8'hFF);
      check("rs_pkt_count", count, 2);
      check("rs_pkt_done",  done, 1);
`ifdef MINMAX_IDX_EN
      check("rs_min_idx", min_idx, 1);
      check("rs_max_idx", max_idx, 0);
`endif

      // Single-sample packet.
      pulse_start();
      send(8'h7F, 1'b1);
      check("one_min",   min_out, 8'h7F);
      check("one_max",   max_out, 8'h7F);
      check("one_count", count, 1);
      check("one_done",  done, 1);

      // Start coincident with a valid sample mid-packet drops the sample.
      pulse_start();
      send(8'h30, 1'b0);
      send(8'h20, 1'b0);
      check("mid_count", count, 2);
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h01;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      check("prio_count", count, 0);
      check("prio_min",   min_out, 0);
      check("prio_ready", in_ready, 1);
      send(8'h05, 1'b1);
      check("prio_pkt_min",   min_out, 8'h05);
      check("prio_pkt_max",   max_out, 8'h05);
      check("prio_pkt_count", count, 1);
      check("prio_pkt_done",  done, 1);

      // Saturation: 10 decreasing samples, CW=3 counter stops at 7.
      pulse_start();
      for (int k = 0; k < 10; k++) begin
         send(8'(100 - 5 * k), 1'b0);
      end
      check("sat_count_wide", count, 10);
      check("sat_count",      s_count, 7);
      check("sat_min",        s_min_out, 8'd55);
      check("sat_max",        s_max_out, 8'd100);
      check("sat_ready",      s_in_ready, 1);
`ifdef MINMAX_IDX_EN
      check("sat_min_idx",      s_min_idx, 7);
      check("sat_min_idx_wide", min_idx, 9);
      check("sat_max_idx",      s_max_idx, 0);
`endif

      // Asynchronous reset mid-packet, away from any clock edge.
      rst_n = 1'b0;
      #2;
      check("ar_count",   count, 0);
      check("ar_s_count", s_count, 0);
      check("ar_min",     min_out, 0);
      check("ar_max",     max_out, 0);
      check("ar_ready",   in_ready, 0);
      check("ar_done",    done, 0);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h33;
      tick();
      tick();
      in_valid = 1'b0;
      check("ar_idle_ready", in_ready, 0);
      check("ar_idle_count", count, 0);
      check("ar_idle_min",   min_out, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
